// File: rtl/mac_pkg.sv
// Shared state encoding, accumulator sizing and result saturation for the vector MAC engine.
package mac_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ACCM = 2'd1;
    localparam state_t BIAS = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam int SAT_W = 64;

    // Wide enough that a full-length job of worst-case products can never wrap.
    function automatic int acc_width(input int a_w, input int b_w, input int lanes, input int cnt_w);
        int prod_w;
        prod_w = (a_w + b_w > 2 * a_w) ? a_w + b_w : 2 * a_w;
        return prod_w + $clog2(lanes) + cnt_w + 1;
    endfunction

    // Returns {ovf, result}; the result is clamped when sat_en is set, else passed through for truncation.
    function automatic logic [SAT_W:0] sat_trunc(input logic signed [SAT_W-1:0] value,
                                                 input logic sat_en, input int out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        logic                    ovf;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        ovf = (value > hi) || (value < lo);
        res = value;
        if (sat_en && value > hi) res = hi;
        if (sat_en && value < lo) res = lo;
        return {ovf, res};
    endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational per-beat term generator: LANES signed products (or a<<A_W in add mode) summed to ACC_W.
module mac_lane_sum
    import mac_pkg::*;
#(
    parameter int A_BITWIDTH = 8,
    parameter int B_BITWIDTH = A_BITWIDTH,
    parameter int LANES      = 4,
    parameter int ACC_W      = 27
) (
    input  logic                           i_add,
    input  logic [LANES*A_BITWIDTH-1:0]    i_data_a,
    input  logic [LANES*B_BITWIDTH-1:0]    i_data_b,
    output logic signed [ACC_W-1:0]        o_sum
);

    logic signed [A_BITWIDTH-1:0] w_a;
    logic signed [B_BITWIDTH-1:0] w_b;

    always_comb begin
        o_sum = '0;
        w_a   = '0;
        w_b   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_a = i_data_a[i*A_BITWIDTH +: A_BITWIDTH];
            w_b = i_data_b[i*B_BITWIDTH +: B_BITWIDTH];
            if (i_add)
                o_sum = o_sum + (ACC_W'(w_a) <<< A_BITWIDTH);
            else
                o_sum = o_sum + ACC_W'(w_a) * ACC_W'(w_b);
        end
    end

endmodule

// File: rtl/mac_vector.sv
// Multi-lane signed MAC engine: accumulates len beats, adds a bias, optionally saturates the result.
module mac_vector
    import mac_pkg::*;
#(
    parameter int A_BITWIDTH   = 8,
    parameter int B_BITWIDTH   = A_BITWIDTH,
    parameter int LANES        = 4,
    parameter int OUT_BITWIDTH = 20,
    parameter int C_BITWIDTH   = OUT_BITWIDTH - 1,
    parameter int CNT_BITWIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [CNT_BITWIDTH-1:0]            len,
    input  logic                               add,
    input  logic                               sat_en,
    input  logic signed [C_BITWIDTH-1:0]       data_c,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*A_BITWIDTH-1:0]        data_a,
    input  logic [LANES*B_BITWIDTH-1:0]        data_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [OUT_BITWIDTH-1:0]     out,
    output logic                               ovf,
    output logic                               busy
);

    localparam int ACC_W = acc_width(A_BITWIDTH, B_BITWIDTH, LANES, CNT_BITWIDTH);

    state_t                          r_state;
    logic [CNT_BITWIDTH-1:0]         r_len;
    logic [CNT_BITWIDTH-1:0]         r_cnt;
    logic                            r_add;
    logic                            r_sat;
    logic signed [C_BITWIDTH-1:0]    r_c;
    logic signed [ACC_W-1:0]         r_acc;
    logic signed [OUT_BITWIDTH-1:0]  r_out;
    logic                            r_ovf;

    logic signed [ACC_W-1:0]         w_sum;
    logic signed [ACC_W:0]           w_total;
    logic signed [SAT_W-1:0]         w_total_ext;
    logic signed [OUT_BITWIDTH-1:0]  w_res;
    logic                            w_res_ovf;

    mac_lane_sum #(
        .A_BITWIDTH (A_BITWIDTH),
        .B_BITWIDTH (B_BITWIDTH),
        .LANES      (LANES),
        .ACC_W      (ACC_W)
    ) u_lane_sum (
        .i_add    (r_add),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .o_sum    (w_sum)
    );

    assign w_total     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_c);
    assign w_total_ext = SAT_W'(w_total);
    assign w_res       = OUT_BITWIDTH'(sat_trunc(w_total_ext, r_sat, OUT_BITWIDTH));
    assign w_res_ovf   = 1'(sat_trunc(w_total_ext, r_sat, OUT_BITWIDTH) >> SAT_W);

    assign in_ready  = (r_state == ACCM);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out       = r_out;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_add   <= 1'b0;
            r_sat   <= 1'b0;
            r_c     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_add   <= add;
                        r_sat   <= sat_en;
                        r_c     <= data_c;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= (len == '0) ? BIAS : ACCM;
                    end
                end
                ACCM: begin
                    if (in_valid) begin
                        r_acc <= r_acc + w_sum;
                        r_cnt <= r_cnt + CNT_BITWIDTH'(1);
                        if (r_cnt == r_len - CNT_BITWIDTH'(1))
                            r_state <= BIAS;
                    end
                end
                BIAS: begin
                    r_out   <= w_res;
                    r_ovf   <= w_res_ovf;
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vector.sv
// Directed bench for mac_vector with a plain-arithmetic dot-product model and a per-cycle result checker.
module tb_mac_vector;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               add;
    logic               sat_en;
    logic signed [18:0] data_c;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        data_a;
    logic [31:0]        data_b;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] out;
    logic               ovf;
    logic               busy;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    bit     exp_armed = 0;
    longint exp_out   = 0;
    bit     exp_ovf   = 0;
    int     ba [0:15][0:3];
    int     bb [0:15][0:3];

    mac_vector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .add       (add),
        .sat_en    (sat_en),
        .data_c    (data_c),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: dot product over all beats, plus bias, then clamp or wrap to 20 bits.
    function automatic longint mdl_sum(input int n, input bit addm);
        longint s = 0;
        for (int k = 0; k < n; k++)
            for (int l = 0; l < 4; l++)
                s += addm ? longint'(ba[k][l]) * 256 : longint'(ba[k][l]) * longint'(bb[k][l]);
        return s;
    endfunction

    task automatic mdl_final(input longint tot, input bit sat, output longint o, output bit v);
        longint lim = 524288;
        v = (tot > lim - 1) || (tot < -lim);
        if (sat) o = (tot > lim - 1) ? lim - 1 : ((tot < -lim) ? -lim : tot);
        else begin
            o = ((tot % 1048576) + 1048576) % 1048576;
            if (o >= lim) o -= 1048576;
        end
    endtask

    // Result checker: every cycle a result is presented it must be the modelled one.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("valid_expected", 1, longint'(exp_armed));
            if (exp_armed) begin
                check("out", longint'(out), exp_out);
                check("ovf", longint'(ovf), longint'(exp_ovf));
            end
        end
    end

    task automatic fill_const(input int n, input int av, input int bv);
        for (int k = 0; k < n; k++)
            for (int l = 0; l < 4; l++) begin
                ba[k][l] = av;
                bb[k][l] = bv;
            end
    endtask

    task automatic drive_beat(input int k);
        int tmp;
        for (int l = 0; l < 4; l++) begin
            tmp = ba[k][l];
            data_a[l*8 +: 8] = tmp[7:0];
            tmp = bb[k][l];
            data_b[l*8 +: 8] = tmp[7:0];
        end
    endtask

    task automatic run_job(input string nm, input int n, input bit addm, input bit sat,
                           input longint c, input int gap, input longint lit_out,
                           input bit lit_ovf, input bit chk_lat, input int hold);
        longint o;
        bit     v;
        int     t0;
        int     w;
        bit     saw_ready;
        mdl_final(mdl_sum(n, addm) + c, sat, o, v);
        check({nm, "_model_out"}, o, lit_out);
        check({nm, "_model_ovf"}, longint'(v), longint'(lit_ovf));
        exp_out = o;
        exp_ovf = v;
        exp_armed = 1;
        start = 1; len = 8'(n); add = addm; sat_en = sat; data_c = c[18:0];
        @(negedge clk);
        start = 0;
        t0 = cyc;
        saw_ready = 0;
        for (int k = 0; k < n; k++) begin
            in_valid = 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            drive_beat(k);
            in_valid = 1;
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) check({nm, "_ready_timeout"}, 0, 1);
            @(negedge clk);
            in_valid = 0;
        end
        if (n > 0) check({nm, "_ready_low_after_last"}, longint'(in_ready), 0);
        w = 0;
        while (!out_valid && w < 50) begin
            if (in_ready) saw_ready = 1;
            @(negedge clk);
            w++;
        end
        check({nm, "_valid_seen"}, longint'(out_valid), 1);
        if (chk_lat) check({nm, "_latency"}, longint'(cyc - t0), longint'(n + 1));
        if (n == 0) check({nm, "_ready_never"}, longint'(saw_ready), 0);
        check({nm, "_ready_in_done"}, longint'(in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            start = (h < 4) ? h[0] : 1'b0;
            len = 8'd5;
            @(negedge clk);
            check({nm, "_busy_hold"}, longint'(busy), 1);
        end
        start = 0;
        out_ready = 1;
        @(posedge clk);
        #1 exp_armed = 0;
        out_ready = 0;
        @(negedge clk);
        check({nm, "_valid_drop"}, longint'(out_valid), 0);
        check({nm, "_idle"}, longint'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; len = 0; add = 0; sat_en = 0; data_c = 0;
        in_valid = 0; data_a = 0; data_b = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_out", longint'(out), 0);
        rst = 0;
        @(negedge clk);

        // Test 1: simple dot product.
        for (int l = 0; l < 4; l++) begin
            ba[0][l] = l + 1;
            bb[0][l] = l + 5;
        end
        run_job("t1", 1, 0, 0, 10, 0, 80, 0, 1, 0);

        // Test 2: corner operands with bubbles.
        fill_const(3, -128, -128);
        run_job("t2", 3, 0, 0, -1, 2, 196607, 0, 0, 0);

        // Test 3: overflow, saturating and wrapping.
        fill_const(10, -128, -128);
        run_job("t3s", 10, 0, 1, -1, 0, 524287, 1, 1, 0);
        run_job("t3w", 10, 0, 0, -1, 2, -393217, 1, 0, 0);

        // Test 4: add mode ignores b.
        ba[0][0] = 1; ba[0][1] = -1; ba[0][2] = 2; ba[0][3] = 0;
        for (int l = 0; l < 4; l++) bb[0][l] = int'($urandom_range(255)) - 128;
        run_job("t4", 1, 1, 0, 3, 0, 515, 0, 1, 0);

        // Test 5: zero-length job, held result, start ignored while busy.
        run_job("t5", 0, 0, 0, -7, 0, -7, 0, 1, 5);
        repeat (3) @(negedge clk);
        check("t5_no_queued_job", longint'(busy), 0);

        // Test 6: reset mid-job abandons it.
        fill_const(4, 3, 3);
        start = 1; len = 8'd4; add = 0; sat_en = 0; data_c = 0;
        @(negedge clk);
        start = 0;
        drive_beat(0);
        in_valid = 1;
        @(negedge clk);
        drive_beat(1);
        #2 rst = 1;
        #1;
        check("t6_rst_in_ready", longint'(in_ready), 0);
        check("t6_rst_busy", longint'(busy), 0);
        check("t6_rst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        in_valid = 0;
        rst = 0;
        repeat (2) @(negedge clk);
        check("t6_no_result", longint'(out_valid), 0);
        for (int l = 0; l < 4; l++) begin
            ba[0][l] = l + 1;
            bb[0][l] = l + 5;
        end
        run_job("t6_after", 1, 0, 0, 10, 0, 80, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
